// File: rtl/riscv_arb_pkg.sv
// Shared types and constants for the RV32I memory-port arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RSP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  // Fetches always read a full word; the top slices this to XLEN/8 lanes.
  localparam int unsigned FETCH_BE_MAX_W = 16;
  localparam logic [FETCH_BE_MAX_W-1:0] FETCH_BE = '1;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter sharing a single-outstanding memory port between
// instruction fetch and the load/store unit. Data has fixed priority; a
// streak counter bounds how many data grants can pass a waiting fetch.
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ALEN        = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ALEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ALEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ALEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err
);

  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  arb_state_t    state, state_nxt;
  arb_owner_t    owner, pick, sel;
  logic [SW-1:0] streak;
  logic          req_any, req_on, gnt_on, rsp_hit;

  // Fixed data priority, overridden once fetch has waited out a full streak.
  always_comb begin
    req_any = if_req | d_req;
    pick    = OWN_D;
    if (if_req && (!d_req || streak == STREAK_MAX)) pick = OWN_IF;
  end

  // Next state and all combinational outputs; everything is held at zero
  // while reset is asserted.
  always_comb begin
    state_nxt = state;
    sel       = owner;
    req_on    = 1'b0;
    rsp_hit   = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB_IDLE: begin
          sel    = pick;
          req_on = req_any;
          if (req_any) state_nxt = mem_gnt ? ARB_RSP : ARB_REQ;
        end
        ARB_REQ: begin
          req_on = 1'b1;
          if (mem_gnt) state_nxt = ARB_RSP;
        end
        ARB_RSP: begin
          if (mem_rvalid) begin
            rsp_hit   = 1'b1;
            state_nxt = ARB_IDLE;
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end

    gnt_on    = req_on & mem_gnt;
    mem_req   = req_on;
    if_gnt    = gnt_on & (sel == OWN_IF);
    d_gnt     = gnt_on & (sel == OWN_D);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (req_on) begin
      if (sel == OWN_D) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end else begin
        mem_addr  = if_addr;
        mem_be    = FETCH_BE[BW-1:0];
      end
    end

    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    if (rsp_hit) begin
      if (owner == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
        d_err    = mem_err;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
        if_err    = mem_err;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Owner is captured whenever IDLE launches a request, granted or not,
  // so a late-rising competitor cannot steal a request stuck in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                owner <= OWN_IF;
    else if (state == ARB_IDLE && req_any)  owner <= pick;
  end

  // Consecutive data grants seen by a waiting fetch, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  streak <= '0;
    else if (!if_req || if_gnt)               streak <= '0;
    else if (d_gnt && streak != STREAK_MAX)   streak <= streak + 1'b1;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: requester and memory models
// driven per cycle, grant order and responses tracked by scoreboard queues.
module tb_riscv_mem_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ALEN = 32;
  localparam int unsigned MAXS = 4;

  logic            clk, rst;
  logic            if_req, if_gnt, if_rvalid, if_err;
  logic [ALEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [ALEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata, d_rdata;
  logic [3:0]      d_be;
  logic            mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata, mem_rdata;
  logic [3:0]      mem_be;

  riscv_mem_arbiter #(.XLEN(XLEN), .ALEN(ALEN), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t rsp_q[$];
  logic gnt_q[$];   // 1 = data expected to win, 0 = fetch

  int nvec = 0;
  int nerr = 0;

  // Requester models: counts of outstanding requests and their fields.
  int          if_left = 0, d_left = 0;
  logic [31:0] if_a = '0, d_a = '0, d_wd = '0;
  logic        d_w = 1'b0;
  logic [3:0]  d_b = 4'hF;
  logic        rst_v = 1'b1;

  // Memory model knobs.
  int          gnt_wait = 0;
  logic        rsp_due = 1'b0, rsp_err = 1'b0, hold_rsp = 1'b0;
  logic        err_next = 1'b0, inject_rv = 1'b0;
  logic [31:0] rsp_data = '0;

  int dcnt = 0, maxd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfun(input logic [31:0] a);
    if (a == 32'h100) return 32'h00A00093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // One clock: drive inputs just after posedge, observe at negedge.
  task automatic step();
    logic        exp_d;
    logic [31:0] ea;
    rsp_t        e;
    @(posedge clk);
    #1;
    rst        = rst_v;
    if_req     = (if_left > 0);
    d_req      = (d_left > 0);
    if_addr    = if_a;
    d_addr     = d_a;
    d_we       = d_w;
    d_wdata    = d_wd;
    d_be       = d_b;
    mem_gnt    = (gnt_wait == 0);
    if (gnt_wait > 0) gnt_wait--;
    mem_rvalid = rsp_due | inject_rv;
    mem_rdata  = inject_rv ? 32'hDEADBEEF : rsp_data;
    mem_err    = rsp_due & rsp_err;
    rsp_due    = 1'b0;
    inject_rv  = 1'b0;
    @(negedge clk);

    check("gnt_excl", 32'(if_gnt & d_gnt), 32'd0);

    if (if_gnt || d_gnt) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexp", {30'd0, if_gnt, d_gnt}, 32'd0);
        exp_d = d_gnt;
      end else begin
        exp_d = gnt_q.pop_front();
        check("gnt_who", 32'(d_gnt), 32'(exp_d));
      end
      ea = exp_d ? d_a : if_a;
      check("gnt_addr", mem_addr, ea);
      check("gnt_we", 32'(mem_we), exp_d ? 32'(d_w) : 32'd0);
      check("gnt_wdata", mem_wdata, exp_d ? d_wd : 32'd0);
      check("gnt_be", 32'(mem_be), exp_d ? 32'(d_b) : 32'hF);
      rsp_q.push_back('{is_d: exp_d, data: memfun(ea), err: err_next});
      rsp_err  = err_next;
      err_next = 1'b0;
      if (!hold_rsp) begin
        rsp_due  = 1'b1;
        rsp_data = memfun(mem_addr);
      end
      if (d_gnt && if_req) dcnt++;
      if (if_gnt) dcnt = 0;
      if (dcnt > maxd) maxd = dcnt;
      if (if_gnt) begin if_left--; if_a += 32'd4; end
      if (d_gnt)  begin d_left--;  d_a  += 32'd4; d_wd = d_wd + 32'h01010101; end
    end

    if (if_rvalid || d_rvalid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexp", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        check("rv_d", 32'(d_rvalid), 32'(e.is_d));
        check("rv_if", 32'(if_rvalid), 32'(!e.is_d));
        check("rv_data", e.is_d ? d_rdata : if_rdata, e.data);
        check("rv_other", e.is_d ? if_rdata : d_rdata, 32'd0);
        check("rv_err", e.is_d ? 32'(d_err) : 32'(if_err), 32'(e.err));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {20'd0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                          mem_req, mem_we, mem_be}, 32'd0);
    check({tag, "_data"}, if_rdata | d_rdata | mem_addr | mem_wdata, 32'd0);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      done = (gnt_q.size() == 0) && (rsp_q.size() == 0) && !rsp_due
             && (if_left == 0) && (d_left == 0);
      if (done) break;
      step();
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  // Requesters must hold their request until granted.
  a_if_hold: assert property (@(posedge clk) disable iff (rst) (if_req && !if_gnt) |=> if_req)
    else $error("FAIL if_req_hold got=0 exp=1");
  a_d_hold: assert property (@(posedge clk) disable iff (rst) (d_req && !d_gnt) |=> d_req)
    else $error("FAIL d_req_hold got=0 exp=1");

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    d_we = 1'b0; d_wdata = '0; d_be = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; mem_err = 1'b0;

    // Reset: outputs quiet, even with a response pulse on the bus.
    rst_v = 1'b1;
    inject_rv = 1'b1;
    step();
    check_all_zero("reset");
    step();
    check_all_zero("reset2");
    rst_v = 1'b0;
    step();
    check("idle_mreq", 32'(mem_req), 32'd0);

    // Fetch only: zero-latency grant, response one cycle later.
    if_left = 1; if_a = 32'h100; gnt_q.push_back(1'b0);
    step();
    check("fo_gnt", 32'(if_gnt), 32'd1);
    check("fo_addr", mem_addr, 32'h100);
    step();
    check("fo_rvalid", 32'(if_rvalid), 32'd1);
    check("fo_rdata", if_rdata, 32'h00A00093);
    check("fo_dquiet", {28'd0, d_gnt, d_rvalid, d_err, |d_rdata}, 32'd0);
    drain("fo", 10);

    // Error routing on a misaligned load.
    d_left = 1; d_a = 32'h2003; d_w = 1'b0; d_b = 4'hF; err_next = 1'b1;
    gnt_q.push_back(1'b1);
    step();
    step();
    check("err_drv", 32'(d_rvalid), 32'd1);
    check("err_derr", 32'(d_err), 32'd1);
    check("err_ifrv", 32'(if_rvalid), 32'd0);
    drain("err", 10);

    // Spurious rvalid in IDLE is dropped and the FSM stays in IDLE.
    inject_rv = 1'b1;
    step();
    check("spur_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    check("spur_mreq", 32'(mem_req), 32'd0);
    if_left = 1; if_a = 32'h180; gnt_q.push_back(1'b0);
    step();
    check("spur_idle_gnt", 32'(if_gnt), 32'd1);
    drain("spur", 10);

    // Owner lock: fetch stuck in REQ keeps the port while data arrives.
    if_left = 1; if_a = 32'h500; gnt_wait = 3;
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    step();
    check("lock_addr0", mem_addr, 32'h500);
    d_left = 1; d_a = 32'h600; d_w = 1'b1; d_wd = 32'hCAFE0000; d_b = 4'h3;
    for (int c = 1; c < 3; c++) begin
      step();
      check("lock_addr", mem_addr, 32'h500);
      check("lock_dgnt", 32'(d_gnt), 32'd0);
    end
    step();
    check("lock_ifgnt", 32'(if_gnt), 32'd1);
    step();
    check("lock_rsp_dgnt", {30'd0, mem_req, d_gnt}, 32'd0);
    step();
    check("lock_idle_dgnt", 32'(d_gnt), 32'd1);
    drain("lock", 10);

    // Contention: both held for 12 transactions.
    if_left = 2; if_a = 32'h1000; d_left = 10; d_a = 32'h8000; d_w = 1'b1;
    d_wd = 32'h11111111; d_b = 4'hF; dcnt = 0; maxd = 0;
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
    gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
    gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
    drain("cont", 100);
    check("cont_maxd", 32'(maxd), 32'(MAXS));

    // Reset while a write waits in RSP; stale rvalid afterwards is dropped.
    d_left = 1; d_a = 32'h3000; d_w = 1'b1; d_wd = 32'h55AA55AA; d_b = 4'hF;
    hold_rsp = 1'b1; gnt_q.push_back(1'b1);
    step();
    hold_rsp = 1'b0;
    step();
    rst_v = 1'b1; if_left = 1; if_a = 32'h400; inject_rv = 1'b1;
    rsp_q.delete();
    step();
    check_all_zero("midrst");
    rst_v = 1'b0; inject_rv = 1'b1; gnt_q.push_back(1'b0);
    step();
    check("stale_rv", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    check("postrst_gnt", 32'(if_gnt), 32'd1);
    drain("postrst", 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
